// File: rtl/image_loader_if.sv
// Byte-stream ingress plus single-word RAM write port of the image loader.
// Latency: n/a (wires only).
// Backpressure: s_ready throttles the byte stream, mem_ready stalls the write.
//
// Signals:
//   s_valid/s_data/s_ready         byte stream from host or UART bridge
//   mem_we/mem_addr/mem_wdata      write request towards the RAM
//   mem_ready                      RAM accepts the current write
// The master modport is the environment: it drives the stream and answers
// the RAM handshake. The slave modport is the loader itself.
interface image_loader_if #(
   parameter int ADDR_WIDTH = 16
);
   logic                  s_valid;
   logic [7:0]            s_data;
   logic                  s_ready;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [63:0]           mem_wdata;
   logic                  mem_ready;

   modport master (
      output s_valid, s_data, mem_ready,
      input  s_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  s_valid, s_data, mem_ready,
      output s_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/image_loader.sv
// Loads a length-prefixed little-endian program image into RAM, then releases the core.
// Latency: write issued 1 cycle after a word's 8th byte; done 1 cycle after last write (or checksum byte).
// Backpressure: s_ready low while writing or terminal; a low mem_ready holds the write indefinitely.
//
// Ports:
//   clk, rst        single clock, asynchronous active-low reset
//   bus (slave)     byte stream in, RAM write request out
//   core_rst_n      core reset, released only once the image is complete
//   done, error     sticky completion / malformed-image flags
// Optional feature: define LOADER_CHKSUM_EN to require a trailing XOR
// checksum byte over the payload (header excluded).
module image_loader #(
   parameter int ADDR_WIDTH = 16,
   parameter int BASE_ADDR  = 0
) (
   input  logic           clk,
   input  logic           rst,
   image_loader_if.slave  bus,
   output logic           core_rst_n,
   output logic           done,
   output logic           error
);

   typedef enum logic [2:0] {HDR, DATA, WRITE, CHK, DONE, ERR} state_t;

   localparam logic [32:0]           MAX_WORDS = 33'd1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);

   state_t                state, state_nxt;
   logic [2:0]            byte_cnt;
   logic [31:0]           word_cnt;
   logic [31:0]           hdr_nxt;
   logic [ADDR_WIDTH:0]   word_idx;    // one extra bit so it can reach 2^ADDR_WIDTH
   logic [63:0]           shreg;
   logic [63:0]           word_nxt;
   logic                  s_fire;
   logic                  w_fire;
   logic                  last_word;
`ifdef LOADER_CHKSUM_EN
   logic [7:0]            csum;
`endif

   // Bytes enter at the top and shift down, so the first byte ends in [7:0].
   assign hdr_nxt   = {bus.s_data, word_cnt[31:8]};
   assign word_nxt  = {bus.s_data, shreg[63:8]};
   assign s_fire    = bus.s_valid && bus.s_ready;
   assign w_fire    = bus.mem_we && bus.mem_ready;
   assign last_word = (33'(word_idx) + 33'd1) == {1'b0, word_cnt};

   always_comb begin
      state_nxt = state;
      case (state)
         HDR: begin
            if (s_fire && byte_cnt == 3'd3) begin
               if (hdr_nxt == 32'd0) begin
`ifdef LOADER_CHKSUM_EN
                  state_nxt = CHK;     // empty image still carries a checksum byte
`else
                  state_nxt = DONE;
`endif
               end else if ({1'b0, hdr_nxt} > MAX_WORDS) begin
                  state_nxt = ERR;
               end else begin
                  state_nxt = DATA;
               end
            end
         end
         DATA: begin
            if (s_fire && byte_cnt == 3'd7) state_nxt = WRITE;
         end
         WRITE: begin
            if (w_fire) begin
               if (last_word) begin
`ifdef LOADER_CHKSUM_EN
                  state_nxt = CHK;
`else
                  state_nxt = DONE;
`endif
               end else begin
                  state_nxt = DATA;
               end
            end
         end
`ifdef LOADER_CHKSUM_EN
         CHK: begin
            if (s_fire) state_nxt = (bus.s_data == csum) ? DONE : ERR;
         end
`endif
         DONE:    state_nxt = DONE;
         ERR:     state_nxt = ERR;
         default: state_nxt = ERR;
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= HDR;
         byte_cnt      <= 3'd0;
         word_cnt      <= 32'd0;
         word_idx      <= '0;
         shreg         <= 64'd0;
         bus.s_ready   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= 64'd0;
         core_rst_n    <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
`ifdef LOADER_CHKSUM_EN
         csum          <= 8'd0;
`endif
      end else begin
         state       <= state_nxt;
         bus.s_ready <= (state_nxt == HDR) || (state_nxt == DATA) || (state_nxt == CHK);
         bus.mem_we  <= (state_nxt == WRITE);
         done        <= (state_nxt == DONE);
         core_rst_n  <= (state_nxt == DONE);
         error       <= (state_nxt == ERR);

         if (s_fire && state == HDR) begin
            word_cnt <= hdr_nxt;
            byte_cnt <= (byte_cnt == 3'd3) ? 3'd0 : byte_cnt + 3'd1;
         end

         if (s_fire && state == DATA) begin
            shreg    <= word_nxt;
            byte_cnt <= byte_cnt + 3'd1;   // wraps to 0 after the eighth byte
`ifdef LOADER_CHKSUM_EN
            csum     <= csum ^ bus.s_data;
`endif
            if (byte_cnt == 3'd7) begin
               bus.mem_wdata <= word_nxt;
               bus.mem_addr  <= BASE + word_idx[ADDR_WIDTH-1:0];
            end
         end

         if (w_fire) word_idx <= word_idx + 1'b1;
      end
   end

endmodule

// File: tb/tb_image_loader.sv
module tb_image_loader;

   typedef struct {
      logic [15:0] addr;
      logic [63:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic core_rst_n, done, error;

   image_loader_if #(.ADDR_WIDTH(16)) bus();

   image_loader #(.ADDR_WIDTH(16), .BASE_ADDR(0)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus.slave),
      .core_rst_n (core_rst_n),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   int vectors    = 0;
   int miscompares = 0;

   // expected behaviour derived from the stream
   logic [7:0] stream[$];
   wr_t        exp_q[$];
   int         exp_n;
   bit         hdr_term;
   bit         exp_done, exp_err;
   int         exp_consumed;
   int         stall_word = -1;
   int         stall_len  = 0;

   // monitor state
   int          edge_no = 0;
   int          acc_cnt, wr_cnt, we_len, stall_left;
   int          prev_acc_idx, first_acc, last_hs;
   bit          term_reached, ev_prev, prev_hs, prev_we;
   logic [15:0] prev_addr;
   logic [63:0] prev_data;
   logic [63:0] mem [0:31];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) edge_no++;

   task automatic push_hdr(input logic [31:0] n);
      for (int b = 0; b < 4; b++) stream.push_back(n[8*b +: 8]);
   endtask

   task automatic push_word(input logic [63:0] w);
      for (int b = 0; b < 8; b++) stream.push_back(w[8*b +: 8]);
   endtask

   task automatic push_csum(input bit corrupt);
`ifdef LOADER_CHKSUM_EN
      logic [7:0] x = 8'h00;
      for (int i = 4; i < stream.size(); i++) x ^= stream[i];
      stream.push_back(corrupt ? (x ^ 8'h01) : x);
`else
      if (corrupt) stall_word = stall_word;
`endif
   endtask

   // Interpret the stream as the image format defines it.
   task automatic build_model();
      logic [31:0] n32;
      logic [63:0] d;
      logic [7:0]  x;
      wr_t         w;
      n32 = {stream[3], stream[2], stream[1], stream[0]};
      exp_q.delete();
      exp_n = 0; hdr_term = 0; exp_done = 0; exp_err = 0;
      if (n32 > 32'd65536) begin
         exp_err = 1; hdr_term = 1; exp_consumed = 4;
      end else begin
         exp_n = int'(n32);
         x = 8'h00;
         for (int i = 0; i < exp_n; i++) begin
            d = 64'd0;
            for (int b = 0; b < 8; b++) begin
               d = d | (64'(stream[4 + 8*i + b]) << (8*b));
               x ^= stream[4 + 8*i + b];
            end
            w.addr = 16'(i);
            w.data = d;
            exp_q.push_back(w);
         end
`ifdef LOADER_CHKSUM_EN
         exp_consumed = 4 + 8*exp_n + 1;
         if (stream[4 + 8*exp_n] == x) exp_done = 1; else exp_err = 1;
`else
         exp_consumed = 4 + 8*exp_n;
         exp_done = 1;
         if (exp_n == 0) hdr_term = 1;
`endif
      end
   endtask

   // RAM responder and per-cycle compare, sampled on the falling edge.
   always @(negedge clk) begin
      bit hs, acc, ev;
      int idx;
      if (!rst) begin
         chk("reset_ctl", {bus.s_ready, bus.mem_we, core_rst_n, done, error}, 5'b0);
         chk("reset_bus", {bus.mem_addr, bus.mem_wdata}, 80'd0);
         bus.mem_ready = 1'b1;
         acc_cnt = 0; wr_cnt = 0; we_len = 0; stall_left = stall_len;
         prev_acc_idx = -1; first_acc = -1; last_hs = -1;
         term_reached = 0; ev_prev = 0; prev_hs = 0; prev_we = 0;
      end else begin
         if (ev_prev) term_reached = 1;
         if (prev_acc_idx >= 4 && prev_acc_idx < 4 + 8*exp_n && ((prev_acc_idx - 4) % 8) == 7)
            chk("we_after_8th", bus.mem_we, 1'b1);
         chk("done_error", {done, error}, term_reached ? {exp_done, exp_err} : 2'b00);
         chk("core_rst_n", core_rst_n, term_reached && exp_done);
         if (done || error) chk("s_ready_terminal", bus.s_ready, 1'b0);
         if (bus.mem_we) begin
            chk("s_ready_writing", bus.s_ready, 1'b0);
            if (exp_q.size() == 0) chk("extra_write", bus.mem_we, 1'b0);
            else begin
               chk("mem_addr", bus.mem_addr, exp_q[0].addr);
               chk("mem_wdata", bus.mem_wdata, exp_q[0].data);
            end
            if (prev_we && !prev_hs) begin
               chk("hold_addr", bus.mem_addr, prev_addr);
               chk("hold_data", bus.mem_wdata, prev_data);
            end
            if (wr_cnt == stall_word && stall_left > 0) begin
               bus.mem_ready = 1'b0;
               stall_left--;
            end else bus.mem_ready = 1'b1;
            we_len++;
         end else bus.mem_ready = 1'b1;

         hs  = bus.mem_we && bus.mem_ready;
         acc = bus.s_valid && bus.s_ready;
         ev  = 0;
         if (acc) begin
            idx = acc_cnt;
            acc_cnt++;
            if (first_acc < 0) first_acc = edge_no + 1;
            if (idx == 3 && hdr_term) ev = 1;
`ifdef LOADER_CHKSUM_EN
            if (!hdr_term && idx == 4 + 8*exp_n) ev = 1;
`endif
            prev_acc_idx = idx;
         end else prev_acc_idx = -1;
         if (hs) begin
            chk("we_len", we_len, 1 + ((wr_cnt == stall_word) ? stall_len : 0));
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (wr_cnt < 32) mem[wr_cnt] = bus.mem_wdata;
            wr_cnt++;
            last_hs = edge_no + 1;
            we_len = 0;
`ifndef LOADER_CHKSUM_EN
            if (wr_cnt == exp_n) ev = 1;
`endif
         end
         ev_prev   = ev;
         prev_hs   = hs;
         prev_we   = bus.mem_we;
         prev_addr = bus.mem_addr;
         prev_data = bus.mem_wdata;
      end
   end

   task automatic do_reset();
      bus.s_valid = 1'b0;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic do_release();
      build_model();
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 chk("s_ready_rise", bus.s_ready, 1'b1);
   endtask

   task automatic run_stream(input int gap_pct, input int nbytes);
      int  i = 0;
      int  cyc = 0;
      bit  a;
      while (i < nbytes && cyc < 4000) begin
         bus.s_valid = ($urandom_range(99) >= gap_pct);
         bus.s_data  = stream[i];
         @(negedge clk);
         a = bus.s_valid && bus.s_ready;
         @(posedge clk);
         #1;
         if (a) i++;
         cyc++;
      end
      bus.s_valid = 1'b0;
      chk("bytes_sent", i, nbytes);
   endtask

   task automatic finish_test();
      int cyc = 0;
      while (!(done || error) && cyc < 50) begin
         @(posedge clk);
         #1 cyc++;
      end
      bus.s_valid = 1'b1;
      bus.s_data  = 8'hA5;
      repeat (10) @(posedge clk);
      #1 bus.s_valid = 1'b0;
      chk("terminal_reached", term_reached, 1'b1);
      chk("write_count", wr_cnt, exp_n);
      chk("bytes_consumed", acc_cnt, exp_consumed);
      chk("writes_pending", exp_q.size(), 0);
   endtask

   initial begin
      bus.s_valid   = 1'b0;
      bus.s_data    = 8'h00;
      bus.mem_ready = 1'b1;

      // two words, no stalls
      do_reset();
      stream.delete();
      push_hdr(32'd2); push_word(64'h1122334455667788); push_word(64'h13); push_csum(0);
      do_release();
      run_stream(0, stream.size());
      finish_test();
      chk("t1_mem0", mem[0], 64'h1122334455667788);
      chk("t1_mem1", mem[1], 64'h0000000000000013);
      chk("t1_cycles", last_hs - first_acc + 1, 22);
      chk("t1_done", {done, core_rst_n, error}, 3'b110);

      // same stream, RAM stalls 5 cycles on word 0
      stall_word = 0; stall_len = 5;
      do_reset();
      do_release();
      run_stream(0, stream.size());
      finish_test();
      chk("t2_mem0", mem[0], 64'h1122334455667788);
      chk("t2_mem1", mem[1], 64'h0000000000000013);
      chk("t2_cycles", last_hs - first_acc + 1, 27);
      stall_word = -1; stall_len = 0;

      // header one word beyond the address space
      do_reset();
      stream.delete();
      push_hdr(32'h00010001);
      do_release();
      run_stream(0, stream.size());
      finish_test();
      chk("t3_error", {error, done, core_rst_n}, 3'b100);
      chk("t3_writes", wr_cnt, 0);

      // empty image
      do_reset();
      stream.delete();
      push_hdr(32'd0); push_csum(0);
      do_release();
      run_stream(0, stream.size());
      finish_test();
      chk("t4_done", {done, error}, 2'b10);

      // reset mid-word, then a fresh one-word load
      do_reset();
      stream.delete();
      push_hdr(32'd1); push_word(64'hDEADBEEFCAFEF00D);
      do_release();
      run_stream(0, 7);
      do_reset();
      stream.delete();
      push_hdr(32'd1); push_word(64'hA1A2A3A4A5A6A7A8); push_csum(0);
      do_release();
      run_stream(0, stream.size());
      finish_test();
      chk("t5_mem0", mem[0], 64'hA1A2A3A4A5A6A7A8);
      chk("t5_writes", wr_cnt, 1);
      chk("t5_done", done, 1'b1);

`ifdef LOADER_CHKSUM_EN
      // checksum good / bad
      do_reset();
      stream.delete();
      push_hdr(32'd1); push_word(64'h0102030405060708); stream.push_back(8'h08);
      do_release();
      run_stream(0, stream.size());
      finish_test();
      chk("t6_done", {done, error, core_rst_n}, 3'b101);
      do_reset();
      stream.delete();
      push_hdr(32'd1); push_word(64'h0102030405060708); stream.push_back(8'h09);
      do_release();
      run_stream(0, stream.size());
      finish_test();
      chk("t6_error", {done, error, core_rst_n}, 3'b010);
`endif

      // sixteen words with random valid gaps
      do_reset();
      stream.delete();
      push_hdr(32'd16);
      for (int i = 0; i < 128; i++) stream.push_back(8'(i));
      push_csum(0);
      do_release();
      run_stream(50, stream.size());
      finish_test();
      chk("t7_mem0", mem[0], 64'h0706050403020100);
      chk("t7_mem15", mem[15], 64'h7F7E7D7C7B7A7978);
      chk("t7_done", done, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
